// File: rtl/floo_latency_delay_buffer.sv
// floo_latency_delay_buffer
// In-order delay buffer for memory-response modelling. Every accepted beat
// waits for a programmable latency, captured when the beat is accepted, before
// it can leave. Outstanding beats are also limited per transaction ID.
// Entries are kept in a circular FIFO. Each entry carries its own remaining-cycle
// counter, so a beat matures at the same time wherever it sits in the queue.
// Release is still strictly in order.

module floo_latency_delay_buffer #(
    parameter  int unsigned DataWidth    = 64,
    parameter  int unsigned IdWidth      = 4,
    parameter  int unsigned Depth        = 32,
    parameter  int unsigned MaxTxnsPerId = 4,
    parameter  int unsigned MaxLatency   = 255,
    localparam int unsigned NumIds       = 2 ** IdWidth,
    localparam int unsigned LatWidth     = $clog2(MaxLatency + 1),
    localparam int unsigned CntWidth     = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [LatWidth-1:0]  latency_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IdWidth-1:0]   in_id_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IdWidth-1:0]   out_id_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic [CntWidth-1:0]  occupancy_o,
    output logic                 id_stall_o
);

    localparam int unsigned PtrWidth   = $clog2(Depth);
    localparam int unsigned IdCntWidth = $clog2(MaxTxnsPerId + 1);

    localparam logic [LatWidth:0]     MaxLatExt = (LatWidth + 1)'(MaxLatency);
    localparam logic [CntWidth-1:0]   DepthV    = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [IdCntWidth-1:0] MaxTxnV   = IdCntWidth'(MaxTxnsPerId);

    // Queue control state
    logic [PtrWidth-1:0]   r_wptr;
    logic [PtrWidth-1:0]   r_rptr;
    logic [CntWidth-1:0]   r_count;
    logic [IdCntWidth-1:0] r_idcnt [NumIds];

    // Entry storage. The contents are not reset; the pointers and the count decide
    // which entries are live.
    logic [IdWidth-1:0]    r_id   [Depth];
    logic [DataWidth-1:0]  r_data [Depth];
    logic [LatWidth-1:0]   r_rem  [Depth];

    logic [LatWidth:0]     w_lat_ext;
    logic [LatWidth-1:0]   w_leff;
    logic                  w_full;
    logic                  w_id_room;
    logic                  w_head_mature;
    logic                  w_push;
    logic                  w_pop;
    logic [IdWidth-1:0]    w_head_id;
    logic [NumIds-1:0]     w_id_inc;
    logic [NumIds-1:0]     w_id_dec;

    // Effective latency: clamp to MaxLatency, and treat 0 as 1 cycle
    always_comb begin
        w_lat_ext = {1'b0, latency_i};
        if (w_lat_ext > MaxLatExt) begin
            w_leff = MaxLatExt[LatWidth-1:0];
        end else if (latency_i == {LatWidth{1'b0}}) begin
            w_leff = {{(LatWidth-1){1'b0}}, 1'b1};
        end else begin
            w_leff = latency_i;
        end
    end

    // Acceptance and release decisions, plus the externally visible status
    always_comb begin
        w_full        = (r_count == DepthV);
        w_id_room     = (r_idcnt[in_id_i] < MaxTxnV);
        w_head_id     = r_id[r_rptr];
        w_head_mature = (r_count != {CntWidth{1'b0}}) && (r_rem[r_rptr] == {LatWidth{1'b0}});

        in_ready_o  = !rst_i && !w_full && w_id_room;
        id_stall_o  = !rst_i && in_valid_i && !w_full && !w_id_room;
        out_valid_o = !rst_i && w_head_mature;

        if (out_valid_o) begin
            out_id_o   = w_head_id;
            out_data_o = r_data[r_rptr];
        end else begin
            out_id_o   = {IdWidth{1'b0}};
            out_data_o = {DataWidth{1'b0}};
        end

        if (rst_i) begin
            occupancy_o = {CntWidth{1'b0}};
        end else begin
            occupancy_o = r_count;
        end

        w_push = in_valid_i && in_ready_o;
        w_pop  = out_valid_o && out_ready_i;
    end

    // Per-ID increment/decrement requests; if both hit the same ID, they cancel
    always_comb begin
        w_id_inc = {NumIds{1'b0}};
        w_id_dec = {NumIds{1'b0}};
        for (int k = 0; k < NumIds; k++) begin
            if (w_push && (in_id_i == IdWidth'(k))) begin
                w_id_inc[k] = 1'b1;
            end else begin
                w_id_inc[k] = 1'b0;
            end
            if (w_pop && (w_head_id == IdWidth'(k))) begin
                w_id_dec[k] = 1'b1;
            end else begin
                w_id_dec[k] = 1'b0;
            end
        end
    end

    // Pointers, fill count and per-ID outstanding counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= {PtrWidth{1'b0}};
            r_rptr  <= {PtrWidth{1'b0}};
            r_count <= {CntWidth{1'b0}};
            for (int k = 0; k < NumIds; k++) begin
                r_idcnt[k] <= {IdCntWidth{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LastPtr) ? {PtrWidth{1'b0}} : r_wptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? {PtrWidth{1'b0}} : r_rptr + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
            for (int k = 0; k < NumIds; k++) begin
                if (w_id_inc[k] && !w_id_dec[k]) begin
                    r_idcnt[k] <= r_idcnt[k] + IdCntWidth'(1);
                end else if (w_id_dec[k] && !w_id_inc[k]) begin
                    r_idcnt[k] <= r_idcnt[k] - IdCntWidth'(1);
                end
            end
        end
    end

    // Entry write on acceptance. Every other entry counts its remaining latency
    // down to 0. Free slots may also count down, which is harmless because a write
    // reloads the counter.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Depth; i++) begin
            if (w_push && (r_wptr == PtrWidth'(i))) begin
                r_id[i]   <= in_id_i;
                r_data[i] <= in_data_i;
                r_rem[i]  <= w_leff - LatWidth'(1);
            end else if (r_rem[i] != {LatWidth{1'b0}}) begin
                r_rem[i]  <= r_rem[i] - LatWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_floo_latency_delay_buffer.sv
// Self-checking bench for floo_latency_delay_buffer.
// The reference model is a queue of beats. Each beat records the cycle from
// which it may be released. Every cycle, all DUT outputs are compared against
// the model, and the model then applies the handshakes it predicts.

module tb_floo_latency_delay_buffer;

    localparam int DW    = 64;
    localparam int IW    = 4;
    localparam int DEPTH = 32;
    localparam int MAXT  = 4;
    localparam int MAXL  = 255;
    localparam int LW    = 8;
    localparam int OW    = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [LW-1:0] latency_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [IW-1:0] in_id_i;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [IW-1:0] out_id_o;
    logic [DW-1:0] out_data_o;
    logic [OW-1:0] occupancy_o;
    logic          id_stall_o;

    floo_latency_delay_buffer #(
        .DataWidth    (DW),
        .IdWidth      (IW),
        .Depth        (DEPTH),
        .MaxTxnsPerId (MAXT),
        .MaxLatency   (MAXL)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .latency_i   (latency_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_id_i     (in_id_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_id_o    (out_id_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o),
        .id_stall_o  (id_stall_o)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        int            rdy;
    } beat_t;

    beat_t q[$];
    int    cyc;
    int    n_chk;
    int    n_pass;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int leff(input int lat);
        if (lat == 0) return 1;
        if (lat > MAXL) return MAXL;
        return lat;
    endfunction

    // One clock cycle: drive inputs, compare every output against the model, then advance the model
    task automatic cycle(input logic rst, input logic v, input logic [IW-1:0] id,
                         input logic [DW-1:0] data, input int lat, input logic ordy);
        int    cnt;
        int    lv;
        logic  mature;
        logic  e_rdy;
        logic  e_push;
        logic  e_pop;
        beat_t b;
        @(negedge clk_i);
        rst_i       = rst;
        in_valid_i  = v;
        in_id_i     = id;
        in_data_i   = data;
        latency_i   = LW'(lat);
        out_ready_i = ordy;
        lv          = int'(latency_i);
        #1;
        cnt = 0;
        foreach (q[i]) if (q[i].id == id) cnt++;
        mature = !rst && (q.size() > 0) && (cyc >= q[0].rdy);
        e_rdy  = !rst && (q.size() < DEPTH) && (cnt < MAXT);
        check_val("in_ready",  64'(in_ready_o),  64'(e_rdy));
        check_val("id_stall",  64'(id_stall_o),  64'(!rst && v && (q.size() < DEPTH) && (cnt >= MAXT)));
        check_val("occupancy", 64'(occupancy_o), rst ? 64'd0 : 64'(q.size()));
        check_val("out_valid", 64'(out_valid_o), 64'(mature));
        check_val("out_id",    64'(out_id_o),    mature ? 64'(q[0].id) : 64'd0);
        check_val("out_data",  out_data_o,       mature ? q[0].data : 64'd0);
        e_push = v && e_rdy;
        e_pop  = mature && ordy;
        @(posedge clk_i);
        if (rst) begin
            q.delete();
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_push) begin
                b.id   = id;
                b.data = data;
                b.rdy  = cyc + leff(lv);
                q.push_back(b);
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 4'd0, 64'd0, 0, ordy);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        cyc         = 0;
        rst_i       = 1'b1;
        latency_i   = '0;
        in_valid_i  = 1'b0;
        in_id_i     = '0;
        in_data_i   = '0;
        out_ready_i = 1'b0;

        // Reset
        repeat (3) cycle(1'b1, 1'b0, 4'd0, 64'd0, 0, 1'b0);

        // Single beat: latency 5, id 3, data 0xA5, accepted in cycle 10
        while (cyc < 10) idle(1'b1);
        cycle(1'b0, 1'b1, 4'd3, 64'hA5, 5, 1'b1);
        repeat (10) idle(1'b1);

        // Latency 0 behaves as 1; latency 255 is the maximum
        cycle(1'b0, 1'b1, 4'd4, rnd64(), 0, 1'b1);
        repeat (4) idle(1'b1);
        cycle(1'b0, 1'b1, 4'd5, rnd64(), 255, 1'b1);
        repeat (260) idle(1'b1);

        // In-order release: a long-latency head blocks a short-latency follower
        cycle(1'b0, 1'b1, 4'd6, rnd64(), 20, 1'b1);
        cycle(1'b0, 1'b1, 4'd7, rnd64(), 2, 1'b1);
        repeat (25) idle(1'b1);

        // Per-ID limit and back-pressure
        repeat (4) cycle(1'b0, 1'b1, 4'd1, rnd64(), 1, 1'b0);
        cycle(1'b0, 1'b1, 4'd1, rnd64(), 1, 1'b0);
        cycle(1'b0, 1'b1, 4'd2, rnd64(), 1, 1'b0);
        cycle(1'b0, 1'b1, 4'd1, rnd64(), 1, 1'b1);
        cycle(1'b0, 1'b1, 4'd1, rnd64(), 1, 1'b0);
        repeat (12) idle(1'b1);

        // Fill to capacity, then pop while full without pass-through, then drain; three passes
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                cycle(1'b0, 1'b1, IW'(i / 4 + p * 4), rnd64(), 1, 1'b0);
            end
            cycle(1'b0, 1'b1, IW'(9 + p), rnd64(), 1, 1'b1);
            repeat (DEPTH + 6) idle(1'b1);
            cycle(1'b0, 1'b1, IW'(p), rnd64(), 2, 1'b1);
        end
        repeat (5) idle(1'b1);

        // Reset with 7 beats in flight, then a fresh beat
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, IW'(i), rnd64(), 30, 1'b1);
        cycle(1'b1, 1'b0, 4'd0, 64'd0, 0, 1'b1);
        cycle(1'b0, 1'b1, 4'd3, rnd64(), 3, 1'b1);
        repeat (6) idle(1'b1);

        // Random traffic over a few IDs so the per-ID limit is hit often
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) != 0),
                  IW'($urandom_range(0, 3)),
                  rnd64(),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (60) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
